n64_eeprom_cmd: RTL and testbench

Byte-level Joybus EEPROM command engine. It consumes decoded command frames from the Joybus PHY and drives the n64_scb EEPROM port (address, wdata, write, rdata) that the block RAM stage serves. It returns response bytes to the PHY for transmission. Supports Info, Read-block and Write-block commands for the 4 kbit and 16 kbit EEPROM variants.

---
 rtl/n64_eeprom_pkg.sv | 24 ++
 rtl/n64_eeprom_cmd.sv | 168 ++++++++++++++++
 tb/tb_n64_eeprom_cmd.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/n64_eeprom_pkg.sv
// n64_eeprom_pkg: shared definitions for the Joybus EEPROM command engine.
// Holds the Joybus command byte values, the default Info identity bytes and
// the engine's state type.
package n64_eeprom_pkg;

  localparam logic [7:0] CMD_INFO  = 8'h00;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] CMD_READ  = 8'h04;
  localparam logic [7:0] CMD_WRITE = 8'h05;

  localparam logic [7:0] ID_4K_DEFAULT  = 8'h80;
  localparam logic [7:0] ID_16K_DEFAULT = 8'hC0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_BLOCK,
    ST_INFO_TX,
    ST_READ_FETCH,
    ST_READ_TX,
    ST_WRITE_DATA,
    ST_STATUS_TX
  } eeprom_state_t;

endpackage

// File: rtl/n64_eeprom_cmd.sv
// n64_eeprom_cmd: byte-level Joybus EEPROM command engine.
// Decodes Info (00/FF), Read-block (04) and Write-block (05) frames coming
// from the Joybus PHY, drives the EEPROM RAM port and returns response bytes.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   eeprom_enabled        0 ignores every frame and aborts any command
//   eeprom_16k            1: 256 blocks, 0: 64 blocks (block[7:6] forced 0)
//   rx_valid/rx_first/rx_data  received byte strobe, command-byte flag, data
//   tx_valid/tx_data/tx_ready  response byte handshake towards the PHY
//   eeprom_address        {block, byte_index}
//   eeprom_write/eeprom_wdata  one-cycle write strobe and data
//   eeprom_rdata          read data, valid one clock after the address
//   busy                  engine not idle
module n64_eeprom_cmd
  import n64_eeprom_pkg::*;
#(
  parameter logic [7:0] ID_4K  = ID_4K_DEFAULT,
  parameter logic [7:0] ID_16K = ID_16K_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        eeprom_enabled,
  input  logic        eeprom_16k,
  input  logic        rx_valid,
  input  logic        rx_first,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [10:0] eeprom_address,
  output logic        eeprom_write,
  output logic [7:0]  eeprom_wdata,
  input  logic [7:0]  eeprom_rdata,
  output logic        busy
);

  eeprom_state_t r_state;
  logic [7:0]    r_block;
  logic [2:0]    r_idx;
  logic          r_cmd_write;
  logic          r_fetch_ph;
  logic          r_tx_valid;
  logic [7:0]    r_tx_data;
  logic [10:0]   r_address;
  logic          r_write;
  logic [7:0]    r_wdata;

  logic [7:0]    w_block;
  logic [7:0]    w_info_byte;

  // 4 kbit parts only have 64 blocks; the upper block bits are ignored.
  assign w_block     = eeprom_16k ? rx_data : {2'b00, rx_data[5:0]};
  assign w_info_byte = (r_idx == 3'd1) ? (eeprom_16k ? ID_16K : ID_4K) : 8'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_block     <= '0;
      r_idx       <= '0;
      r_cmd_write <= 1'b0;
      r_fetch_ph  <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_address   <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
    end else begin
      r_write <= 1'b0;
      if (!eeprom_enabled) begin
        r_state    <= ST_IDLE;
        r_tx_valid <= 1'b0;
      end else if (rx_valid && rx_first) begin
        // A command byte always restarts decode and drops any pending byte.
        r_tx_valid <= 1'b0;
        r_idx      <= '0;
        r_fetch_ph <= 1'b0;
        case (rx_data)
          CMD_INFO, CMD_RESET: r_state <= ST_INFO_TX;
          CMD_READ, CMD_WRITE: begin
            r_cmd_write <= (rx_data == CMD_WRITE);
            r_state     <= ST_GET_BLOCK;
          end
          default: r_state <= ST_IDLE;
        endcase
      end else begin
        case (r_state)
          ST_IDLE: ;
          ST_GET_BLOCK: begin
            if (rx_valid) begin
              r_block <= w_block;
              r_idx   <= '0;
              if (r_cmd_write) begin
                r_state <= ST_WRITE_DATA;
              end else begin
                r_address  <= {w_block, 3'd0};
                r_fetch_ph <= 1'b0;
                r_state    <= ST_READ_FETCH;
              end
            end
          end
          // Each byte is loaded in a cycle where tx_valid is low, so an
          // aborted byte is never replaced in place by a new one.
          ST_INFO_TX: begin
            if (!r_tx_valid) begin
              r_tx_data  <= w_info_byte;
              r_tx_valid <= 1'b1;
            end else if (tx_ready) begin
              r_tx_valid <= 1'b0;
              if (r_idx == 3'd2) r_state <= ST_IDLE;
              else               r_idx   <= r_idx + 3'd1;
            end
          end
          // Phase 0: the RAM samples the address. Phase 1: read data is valid.
          ST_READ_FETCH: begin
            if (!r_fetch_ph) begin
              r_fetch_ph <= 1'b1;
            end else begin
              r_fetch_ph <= 1'b0;
              r_tx_data  <= eeprom_rdata;
              r_tx_valid <= 1'b1;
              r_state    <= ST_READ_TX;
            end
          end
          ST_READ_TX: begin
            if (tx_ready) begin
              r_tx_valid <= 1'b0;
              if (r_idx == 3'd7) begin
                r_state <= ST_IDLE;
              end else begin
                r_idx     <= r_idx + 3'd1;
                r_address <= {r_block, r_idx + 3'd1};
                r_state   <= ST_READ_FETCH;
              end
            end
          end
          ST_WRITE_DATA: begin
            if (rx_valid) begin
              r_wdata   <= rx_data;
              r_address <= {r_block, r_idx};
              r_write   <= 1'b1;
              r_idx     <= r_idx + 3'd1;
              if (r_idx == 3'd7) r_state <= ST_STATUS_TX;
            end
          end
          ST_STATUS_TX: begin
            if (!r_tx_valid) begin
              r_tx_data  <= 8'h00;
              r_tx_valid <= 1'b1;
            end else if (tx_ready) begin
              r_tx_valid <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx_valid       = r_tx_valid;
  assign tx_data        = r_tx_data;
  assign eeprom_address = r_address;
  assign eeprom_write   = r_write;
  assign eeprom_wdata   = r_wdata;
  assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_n64_eeprom_cmd.sv
// tb_n64_eeprom_cmd: scoreboard bench for n64_eeprom_cmd with a one-cycle
// latency RAM model on the EEPROM port.
module tb_n64_eeprom_cmd;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        eeprom_enabled;
  logic        eeprom_16k;
  logic        rx_valid;
  logic        rx_first;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [10:0] eeprom_address;
  logic        eeprom_write;
  logic [7:0]  eeprom_wdata;
  logic [7:0]  eeprom_rdata;
  logic        busy;

  n64_eeprom_cmd #(.ID_4K(8'h80), .ID_16K(8'hC0)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .eeprom_enabled (eeprom_enabled),
    .eeprom_16k     (eeprom_16k),
    .rx_valid       (rx_valid),
    .rx_first       (rx_first),
    .rx_data        (rx_data),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .eeprom_address (eeprom_address),
    .eeprom_write   (eeprom_write),
    .eeprom_wdata   (eeprom_wdata),
    .eeprom_rdata   (eeprom_rdata),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, one clock of latency.
  logic [7:0] mem [0:2047];
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h5A;
  end
  always @(posedge clk) begin
    if (eeprom_write) mem[eeprom_address] <= eeprom_wdata;
    eeprom_rdata <= mem[eeprom_address];
  end

  typedef struct {
    logic [7:0]  data;
    logic        chk_addr;
    logic [10:0] addr;
  } tx_exp_t;

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_exp_t;

  tx_exp_t txq[$];
  wr_exp_t wrq[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_tx     = 0;
  int n_wr     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] d, input logic chk, input logic [10:0] a);
    tx_exp_t e;
    e.data = d; e.chk_addr = chk; e.addr = a;
    txq.push_back(e);
  endtask

  task automatic push_wr(input logic [10:0] a, input logic [7:0] d);
    wr_exp_t e;
    e.addr = a; e.data = d;
    wrq.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every tx handshake and write strobe.
  always @(negedge clk) begin
    if (reset_n) begin
      if (tx_valid && tx_ready) begin
        n_tx++;
        if (txq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_extra: got %0h expected no byte", tx_data);
        end else begin
          tx_exp_t e;
          e = txq.pop_front();
          check("tx_data", 32'(tx_data), 32'(e.data));
          if (e.chk_addr) check("rd_addr", 32'(eeprom_address), 32'(e.addr));
        end
      end
      if (eeprom_write) begin
        n_wr++;
        if (wrq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL wr_extra: got addr %0h data %0h expected no write", eeprom_address, eeprom_wdata);
        end else begin
          wr_exp_t w;
          w = wrq.pop_front();
          check("wr_addr", 32'(eeprom_address), 32'(w.addr));
          check("wr_data", 32'(eeprom_wdata), 32'(w.data));
        end
      end
    end
  end

  task automatic send_byte(input logic first, input logic [7:0] d);
    rx_valid = 1'b1; rx_first = first; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_first = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int cnt = 0;
    while ((busy || txq.size() != 0 || wrq.size() != 0) && cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_checks++;
    if (cnt >= 300) begin
      n_fail++;
      $display("FAIL %s_timeout: got busy=%0d pending tx=%0d wr=%0d expected idle", name, busy, txq.size(), wrq.size());
      txq.delete(); wrq.delete();
    end
  endtask

  task automatic wait_tx_valid(input string name);
    int cnt = 0;
    while (!tx_valid && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    check(name, 32'(tx_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_tx_data"},  32'(tx_data),  32'd0);
    check({tag, "_addr"},     32'(eeprom_address), 32'd0);
    check({tag, "_write"},    32'(eeprom_write), 32'd0);
    check({tag, "_wdata"},    32'(eeprom_wdata), 32'd0);
    check({tag, "_busy"},     32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    logic [7:0]  hold_d;
    reset_n = 1'b0; eeprom_enabled = 1'b1; eeprom_16k = 1'b1;
    rx_valid = 1'b0; rx_first = 1'b0; rx_data = '0; tx_ready = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Info, 16k then 4k
    push_tx(8'h00, 0, '0); push_tx(8'hC0, 0, '0); push_tx(8'h00, 0, '0);
    send_byte(1, 8'h00);
    wait_idle("info16k");
    check("info16k_busy", 32'(busy), 32'd0);
    eeprom_16k = 1'b0;
    push_tx(8'h00, 0, '0); push_tx(8'h80, 0, '0); push_tx(8'h00, 0, '0);
    send_byte(1, 8'hFF);
    wait_idle("info4k");
    eeprom_16k = 1'b1;

    // Write block 3 then read it back
    for (int i = 0; i < 8; i++) push_wr(11'h018 + 11'(i), 8'h11 + 8'(i));
    push_tx(8'h00, 0, '0);
    send_byte(1, 8'h05);
    send_byte(0, 8'h03);
    for (int i = 0; i < 8; i++) send_byte(0, 8'h11 + 8'(i));
    send_byte(0, 8'hEE);  // extra byte after the block is discarded
    wait_idle("write");
    for (int i = 0; i < 8; i++) push_tx(8'h11 + 8'(i), 1, 11'h018 + 11'(i));
    send_byte(1, 8'h04);
    send_byte(0, 8'h03);
    wait_idle("read");

    // 4k masking: block C5 reads block 5
    eeprom_16k = 1'b0;
    for (int i = 0; i < 8; i++) push_tx(8'h28 + 8'(i) ^ 8'h5A, 1, 11'h028 + 11'(i));
    send_byte(1, 8'h04);
    send_byte(0, 8'hC5);
    wait_idle("mask4k");
    eeprom_16k = 1'b1;

    // Backpressure on byte 2 of a read of block 0x85
    for (int i = 0; i < 8; i++) push_tx(8'h28 + 8'(i) ^ 8'h5A, 1, 11'h428 + 11'(i));
    base = n_tx;
    send_byte(1, 8'h04);
    send_byte(0, 8'h85);
    for (int c = 0; c < 100 && n_tx != base + 1; c++) begin @(posedge clk); #1; end
    tx_ready = 1'b0;
    wait_tx_valid("bp_valid");
    hold_d = tx_data;
    check("bp_first_addr", 32'(eeprom_address), 32'h429);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(tx_valid), 32'd1);
      check("bp_hold_data",  32'(tx_data), 32'(hold_d));
      check("bp_hold_addr",  32'(eeprom_address), 32'h429);
    end
    tx_ready = 1'b1;
    wait_idle("bp");

    // Abort a write after 3 bytes with an Info command
    push_wr(11'h008, 8'hAA); push_wr(11'h009, 8'hBB); push_wr(11'h00A, 8'hCC);
    push_tx(8'h00, 0, '0); push_tx(8'hC0, 0, '0); push_tx(8'h00, 0, '0);
    base = n_wr;
    send_byte(1, 8'h05);
    send_byte(0, 8'h01);
    send_byte(0, 8'hAA); send_byte(0, 8'hBB); send_byte(0, 8'hCC);
    send_byte(1, 8'h00);
    wait_idle("abort_wr");
    repeat (5) @(posedge clk); #1;
    check("abort_wr_count", 32'(n_wr - base), 32'd3);

    // Abort while a read byte is pending
    tx_ready = 1'b0;
    send_byte(1, 8'h04);
    send_byte(0, 8'h03);
    wait_tx_valid("abort_rd_valid");
    send_byte(1, 8'hAB);
    check("abort_rd_drop", 32'(tx_valid), 32'd0);
    check("abort_rd_busy", 32'(busy), 32'd0);
    tx_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Asynchronous reset while READ_TX holds a byte
    tx_ready = 1'b0;
    send_byte(1, 8'h04);
    send_byte(0, 8'h03);
    wait_tx_valid("rst_valid");
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk); #1;

    // Disabled engine ignores a read frame
    eeprom_enabled = 1'b0;
    base = n_tx + n_wr;
    send_byte(1, 8'h04);
    send_byte(0, 8'h00);
    repeat (20) @(posedge clk); #1;
    check("disabled_activity", 32'(n_tx + n_wr - base), 32'd0);
    check("disabled_busy", 32'(busy), 32'd0);
    eeprom_enabled = 1'b1;

    check("tx_queue_empty", 32'(txq.size()), 32'd0);
    check("wr_queue_empty", 32'(wrq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
